// File: rtl/grid_io_cfg_tile.sv
// Perimeter I/O tile: NUM_IO pad subtiles configured from a serial scan chain.
// A load controller counts shifted bits and commits full frames atomically into shadow registers.
module grid_io_cfg_tile #(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_head,
  input  logic              ccff_en,
  output logic              ccff_tail,
  output logic              cfg_busy,
  output logic              cfg_done,
  input  logic [NUM_IO-1:0] outpad,
  output logic [NUM_IO-1:0] inpad,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe
);

  localparam int TOTAL = NUM_IO * CFG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TOTAL-1:0] chain;
  logic [TOTAL-1:0] act;
  logic [TOTAL-1:0] chain_next;
  logic             done_q;
  logic             commit;

  // CFG_BITS >= 2 guarantees TOTAL >= 2, so this slice is always legal.
  assign chain_next = {chain[TOTAL-2:0], ccff_head};

  // Commit fires on the shift that completes a frame, so act takes the post-shift value.
  always_comb begin
    commit = 1'b0;
    if (ccff_en) begin
      case (state)
        S_LOAD:  commit = (cnt == CNT_W'(TOTAL - 1));
        default: commit = (TOTAL == 1);
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain  <= '0;
      act    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      state  <= S_IDLE;
    end else begin
      if (ccff_en) chain <= chain_next;
      if (commit) begin
        act    <= chain_next;
        done_q <= 1'b1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (ccff_en) begin
            if (commit) begin
              state <= S_DONE;
              cnt   <= '0;
            end else begin
              state <= S_LOAD;
              cnt   <= CNT_W'(1);
            end
          end
        end
        S_LOAD: begin
          if (ccff_en) begin
            if (commit) begin
              state <= S_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ccff_tail = chain[TOTAL-1];
  assign cfg_busy  = (state == S_LOAD);
  assign cfg_done  = done_q;

  // Reserved bits (b >= 2) of each subtile are stored in act but never read here.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_sub
    logic dir;
    logic inv;
    assign dir        = act[i*CFG_BITS];
    assign inv        = act[i*CFG_BITS+1];
    assign pad_oe[i]  = done_q & dir;
    assign pad_out[i] = done_q & dir & (outpad[i] ^ inv);
    assign inpad[i]   = done_q & ~dir & (pad_in[i] ^ inv);
  end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// Directed bench for grid_io_cfg_tile (NUM_IO=4, CFG_BITS=2); outputs sampled on the falling edge.
module tb_grid_io_cfg_tile;

  logic       prog_clk;
  logic       pReset;
  logic       ccff_head;
  logic       ccff_en;
  logic       ccff_tail;
  logic       cfg_busy;
  logic       cfg_done;
  logic [3:0] outpad;
  logic [3:0] inpad;
  logic [3:0] pad_in;
  logic [3:0] pad_out;
  logic [3:0] pad_oe;

  int checks = 0;
  int errors = 0;

  // Frames are written with the first-shifted bit as the MSB; after a full
  // load chain[k] equals frame[k].
  logic [7:0] frame_a = 8'b0011_1001;
  logic [7:0] frame_b = 8'b1101_1000;

  grid_io_cfg_tile #(.NUM_IO(4), .CFG_BITS(2)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .ccff_head(ccff_head),
    .ccff_en  (ccff_en),
    .ccff_tail(ccff_tail),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .outpad   (outpad),
    .inpad    (inpad),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Inputs change just after a falling edge; one tick = one rising edge.
  task automatic tick();
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  task automatic shift(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    tick();
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pads(input string tag, input logic [3:0] oe, input logic [3:0] po,
                          input logic [3:0] ip);
    chk({tag, "_oe"}, {4'h0, pad_oe}, {4'h0, oe});
    chk({tag, "_out"}, {4'h0, pad_out}, {4'h0, po});
    chk({tag, "_in"}, {4'h0, inpad}, {4'h0, ip});
  endtask

  initial begin
    pReset    = 1'b1;
    ccff_en   = 1'b1;
    ccff_head = 1'b1;
    outpad    = 4'b1111;
    pad_in    = 4'b1111;
    @(negedge prog_clk);
    tick();
    tick();

    // Reset dominates shifting.
    chk("rst_tail", {7'h0, ccff_tail}, 8'h00);
    chk("rst_busy", {7'h0, cfg_busy}, 8'h00);
    chk("rst_done", {7'h0, cfg_done}, 8'h00);
    chk_pads("rst", 4'b0000, 4'b0000, 4'b0000);

    pReset    = 1'b0;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    pad_in    = 4'b0000;
    tick();
    chk("idle_busy", {7'h0, cfg_busy}, 8'h00);

    // Full consecutive load.
    for (int k = 0; k < 7; k++) begin
      shift(frame_a[7-k]);
      chk($sformatf("full_busy%0d", k + 1), {7'h0, cfg_busy}, 8'h01);
      chk($sformatf("full_done%0d", k + 1), {7'h0, cfg_done}, 8'h00);
      chk($sformatf("full_oe%0d", k + 1), {4'h0, pad_oe}, 8'h00);
    end
    shift(frame_a[0]);
    chk("full_busy8", {7'h0, cfg_busy}, 8'h00);
    chk("full_done8", {7'h0, cfg_done}, 8'h01);
    // Subtiles: 0 DIR=1 INV=0, 1 DIR=0 INV=1, 2 DIR=1 INV=1, 3 DIR=0 INV=0.
    chk_pads("full_a", 4'b0101, 4'b0001, 4'b0010);
    outpad = 4'b0000;
    pad_in = 4'b1111;
    #1;
    chk_pads("full_b", 4'b0101, 4'b0100, 4'b1000);

    // Tail streams the previous frame out, first-in first-out.
    outpad = 4'b1111;
    pad_in = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tail%0d", k), {7'h0, ccff_tail}, {7'h0, frame_a[7-k]});
      shift(1'b0);
    end
    chk("tail_done", {7'h0, cfg_done}, 8'h01);
    chk_pads("zero_frame", 4'b0000, 4'b0000, 4'b1010);

    // Gapped load after reset.
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    pad_in = 4'b0000;
    chk("gap_rst_done", {7'h0, cfg_done}, 8'h00);
    for (int k = 0; k < 4; k++) shift(frame_a[7-k]);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk($sformatf("gap_busy%0d", g), {7'h0, cfg_busy}, 8'h01);
      chk($sformatf("gap_done%0d", g), {7'h0, cfg_done}, 8'h00);
    end
    for (int k = 4; k < 7; k++) shift(frame_a[7-k]);
    chk("gap_done7", {7'h0, cfg_done}, 8'h00);
    chk("gap_busy7", {7'h0, cfg_busy}, 8'h01);
    shift(frame_a[0]);
    chk("gap_done8", {7'h0, cfg_done}, 8'h01);
    chk("gap_busy8", {7'h0, cfg_busy}, 8'h00);
    chk_pads("gap", 4'b0101, 4'b0001, 4'b0010);

    // Reload: old config stays live until the new frame commits.
    for (int k = 0; k < 4; k++) shift(1'b1);
    chk("reload_busy", {7'h0, cfg_busy}, 8'h01);
    chk("reload_done", {7'h0, cfg_done}, 8'h01);
    chk_pads("reload_half", 4'b0101, 4'b0001, 4'b0010);
    for (int k = 0; k < 4; k++) shift(1'b1);
    outpad = 4'b0110;
    #1;
    chk("reload_busy_end", {7'h0, cfg_busy}, 8'h00);
    chk_pads("reload_full", 4'b1111, 4'b1001, 4'b0000);

    // Mid-frame reset discards the partial frame and clears the counter.
    for (int k = 0; k < 5; k++) shift(1'b0);
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    chk("mid_busy", {7'h0, cfg_busy}, 8'h00);
    chk("mid_done", {7'h0, cfg_done}, 8'h00);
    chk("mid_tail", {7'h0, ccff_tail}, 8'h00);
    chk_pads("mid", 4'b0000, 4'b0000, 4'b0000);

    outpad = 4'b1111;
    pad_in = 4'b0011;
    for (int k = 0; k < 7; k++) shift(frame_b[7-k]);
    chk("b_busy7", {7'h0, cfg_busy}, 8'h01);
    chk("b_done7", {7'h0, cfg_done}, 8'h00);
    shift(frame_b[0]);
    chk("b_done8", {7'h0, cfg_done}, 8'h01);
    // Subtiles: 0 DIR=0 INV=0, 1 DIR=0 INV=1, 2 DIR=1 INV=0, 3 DIR=1 INV=1.
    chk_pads("frame_b", 4'b1100, 4'b0100, 4'b0001);
    chk("b_tail", {7'h0, ccff_tail}, {7'h0, frame_b[7]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
